// File: rtl/min_press_searcher.sv
// min_press_searcher: tries every button combination through the xor finder and keeps the match with the fewest presses
module min_press_searcher #(
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int MACHINE_COUNT = 10,
    localparam int CNT_W = $clog2(MAX_BUTTON_COUNT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [CNT_W-1:0]            button_count,
    input  logic [MACHINE_COUNT-1:0]    target,
    output logic [MAX_BUTTON_COUNT:0]   combination,
    input  logic [MACHINE_COUNT-1:0]    combination_xor_result,
    output logic                        busy,
    output logic                        done,
    output logic                        found,
    output logic [CNT_W-1:0]            min_presses,
    output logic [MAX_BUTTON_COUNT:0]   best_combination
);
    localparam int CW = MAX_BUTTON_COUNT + 1;
    typedef enum logic [1:0] {IDLE, SEARCH, FINISH} state_t;
    state_t state, state_n;
    logic [MACHINE_COUNT-1:0] target_q;
    logic [CNT_W-1:0] bc, bc_in, pc;
    logic [CW-1:0] last;
    logic better;
    assign bc_in = button_count > CNT_W'(MAX_BUTTON_COUNT) ? CNT_W'(MAX_BUTTON_COUNT) : button_count;
    assign last = (CW'(1) << bc) - CW'(1);
    assign pc = CNT_W'($countones(combination));
    assign better = combination_xor_result == target_q && (!found || pc < min_presses);
    assign busy = state != IDLE;
    assign done = state == FINISH;
    always_comb begin
        state_n = state == IDLE   ? (start ? SEARCH : IDLE) :
                  state == SEARCH ? (combination == last ? FINISH : SEARCH) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            combination <= '0;
            found <= 1'b0;
            min_presses <= '0;
            best_combination <= '0;
            target_q <= '0;
            bc <= '0;
        end else if (state == IDLE && start) begin
            target_q <= target;
            bc <= bc_in;
            found <= 1'b0;
            min_presses <= '0;
            best_combination <= '0;
            combination <= '0;
        end else if (state == SEARCH) begin
            if (better) begin
                found <= 1'b1;
                min_presses <= pc;
                best_combination <= combination;
            end
            if (combination != last) combination <= combination + CW'(1);
        end else if (state == FINISH) begin
            combination <= '0;
        end
    end
endmodule

// File: tb/tb_min_press_searcher.sv
// tb_min_press_searcher: table and random searches against a brute-force model with a behavioural finder
module tb_min_press_searcher;
    localparam int MB = 13;
    localparam int MC = 10;
    localparam int CN = 4;
    localparam int CB = MB + 1;
    logic clk = 1'b0;
    logic rst, start, busy, done, found;
    logic [CN-1:0] button_count, min_presses;
    logic [MC-1:0] target, combination_xor_result;
    logic [MB:0] combination, best_combination;
    logic [MC-1:0] btn [MB];
    int n_vec = 0, n_err = 0;
    bit have_prev = 0;
    bit pf;
    int pm, pb;

    typedef struct {
        int bcin;
        logic [MC-1:0] tgt;
        logic [MB-1:0][MC-1:0] b;
        bit hold;
        bit f;
        int m;
        int best;
        int cyc;
    } vec_t;
    vec_t tab [6];

    min_press_searcher dut (
        .clk(clk), .rst(rst), .start(start), .button_count(button_count), .target(target),
        .combination(combination), .combination_xor_result(combination_xor_result),
        .busy(busy), .done(done), .found(found), .min_presses(min_presses),
        .best_combination(best_combination)
    );

    always #5 clk = ~clk;

    always_comb begin
        combination_xor_result = '0;
        for (int i = 0; i < MB; i++)
            if (combination[i]) combination_xor_result = combination_xor_result ^ btn[i];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [MC-1:0] xor_of(input int c);
        logic [MC-1:0] x = '0;
        for (int i = 0; i < MB; i++) if (c[i]) x = x ^ btn[i];
        return x;
    endfunction

    // fewest presses first, then smallest combination within that press count
    function automatic void model(input int bc, input logic [MC-1:0] tgt,
                                  output bit f, output int m, output int best);
        f = 0; m = 0; best = 0;
        for (int k = 0; k <= bc && !f; k++)
            for (int c = 0; c < (1 << bc) && !f; c++)
                if ($countones(c) == k && xor_of(c) == tgt) begin
                    f = 1; m = k; best = c;
                end
    endfunction

    task automatic run(input int bcin, input logic [MC-1:0] tgt, input bit hold,
                       input bit ef, input int em, input int eb, input int ecyc);
        int bce, cyc, done_at, seq_bad, range_bad;
        logic [CB-1:0] want;
        bce = bcin > MB ? MB : bcin;
        @(negedge clk);
        chk("idle_done_low", done, 0);
        chk("idle_busy_low", busy, 0);
        if (have_prev) begin
            chk("held_found", found, pf);
            chk("held_min", min_presses, pm);
            chk("held_best", best_combination, pb);
        end
        start = 1'b1;
        button_count = CN'(bcin);
        target = tgt;
        @(posedge clk);
        cyc = 0; done_at = -1; seq_bad = 0; range_bad = 0;
        while (done_at < 0 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (!hold) start = 1'b0;
            button_count = CN'($urandom);
            target = MC'($urandom);
            if (cyc == 1) begin
                chk("clear_found", found, 0);
                chk("clear_min", min_presses, 0);
                chk("clear_best", best_combination, 0);
                chk("busy_high", busy, 1);
            end
            want = CB'(cyc - 1);
            if (done) done_at = cyc;
            else if (combination !== want) seq_bad++;
            if ((combination >> bce) != 0) range_bad++;
        end
        chk("done_cycle", done_at, ecyc);
        chk("comb_sequence", seq_bad, 0);
        chk("comb_unused_bits", range_bad, 0);
        chk("found", found, ef);
        chk("min_presses", min_presses, em);
        chk("best_comb", best_combination, eb);
        if (hold) begin
            @(negedge clk);
            start = 1'b0;
            chk("no_restart_busy", busy, 0);
            chk("single_done", done, 0);
        end
        have_prev = 1; pf = ef; pm = em; pb = eb;
    endtask

    initial begin
        bit f;
        int m, b, bc, c, dcount;
        logic [MC-1:0] tgt;
        for (int i = 0; i < 6; i++) begin
            tab[i].b = '0;
            tab[i].hold = 0;
        end
        tab[0].bcin = 6; tab[0].tgt = 10'h006;
        tab[0].b[0] = 10'h008; tab[0].b[1] = 10'h00A; tab[0].b[2] = 10'h004;
        tab[0].b[3] = 10'h00C; tab[0].b[4] = 10'h005; tab[0].b[5] = 10'h003;
        tab[0].f = 1; tab[0].m = 2; tab[0].best = 10; tab[0].cyc = 65;
        tab[1].bcin = 2; tab[1].tgt = 10'h002; tab[1].b[0] = 10'h001; tab[1].b[1] = 10'h001;
        tab[1].f = 0; tab[1].m = 0; tab[1].best = 0; tab[1].cyc = 5;
        tab[2].bcin = 0; tab[2].tgt = 10'h000; tab[2].b[0] = 10'h001;
        tab[2].f = 1; tab[2].m = 0; tab[2].best = 0; tab[2].cyc = 2;
        tab[3].bcin = 0; tab[3].tgt = 10'h001; tab[3].b[0] = 10'h001;
        tab[3].f = 0; tab[3].m = 0; tab[3].best = 0; tab[3].cyc = 2;
        tab[4].bcin = 15; tab[4].tgt = 10'h0A5;
        for (int i = 0; i < MB; i++) tab[4].b[i] = MC'(1) << (i % 10);
        tab[4].b[5] = 10'h0A5; tab[4].b[9] = 10'h0A5;
        tab[4].f = 1; tab[4].m = 1; tab[4].best = 32; tab[4].cyc = 8193;
        tab[5].bcin = 3; tab[5].tgt = 10'h006; tab[5].hold = 1;
        tab[5].b[0] = 10'h001; tab[5].b[1] = 10'h002; tab[5].b[2] = 10'h004;
        tab[5].f = 1; tab[5].m = 2; tab[5].best = 6; tab[5].cyc = 9;

        rst = 1'b1; start = 1'b0; button_count = '0; target = '0;
        for (int i = 0; i < MB; i++) btn[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_comb", combination, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_found", found, 0);
        chk("rst_min", min_presses, 0);
        chk("rst_best", best_combination, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < MB; j++) btn[j] = tab[i].b[j];
            run(tab[i].bcin, tab[i].tgt, tab[i].hold, tab[i].f, tab[i].m, tab[i].best, tab[i].cyc);
        end

        @(negedge clk);
        for (int j = 0; j < MB; j++) btn[j] = 10'h3FF;
        start = 1'b1; button_count = 4'd8; target = 10'h000;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_comb", combination, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_found", found, 0);
        chk("midrst_min", min_presses, 0);
        chk("midrst_best", best_combination, 0);
        dcount = 0;
        repeat (300) begin
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("midrst_quiet", dcount, 0);
        pf = 0; pm = 0; pb = 0;

        for (int r = 0; r < 14; r++) begin
            bc = $urandom_range(0, 10);
            for (int j = 0; j < MB; j++) btn[j] = MC'($urandom);
            c = int'($urandom) & ((1 << bc) - 1);
            tgt = (r % 3 == 2) ? MC'($urandom) : xor_of(c);
            model(bc, tgt, f, m, b);
            run(bc, tgt, r % 4 == 1, f, m, b, (1 << bc) + 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
